pin_entry_ctrl: RTL and testbench

Keypad PIN sequencer that feeds the door-lock FSM of the home security node in the smart-city model. It collects digit keypresses, compares them against a programmable stored PIN, and issues a one-cycle pin_correct pulse that drives the lock FSM's pin_correct input. It enforces a retry limit with a timed lockout, supports re-programming the PIN after a correct entry, and exports locked_out so the system can treat brute-force attempts as an intrusion.

---
 rtl/pin_entry_ctrl.sv | 157 +++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_ctrl.sv
// Keypad PIN sequencer: buffers digit keys, checks them against a programmable PIN,
// enforces a retry limit with timed lockout and supports PIN re-programming.
module pin_entry_ctrl #(
    parameter int PIN_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 32,
    parameter logic [4*PIN_DIGITS-1:0] DEFAULT_PIN = 16'h1234
) (
    input  logic clk,
    input  logic rst,
    input  logic key_valid,
    input  logic [3:0] key_code,
    input  logic prog_en,
    output logic pin_correct,
    output logic pin_wrong,
    output logic pin_changed,
    output logic locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [$clog2(PIN_DIGITS+1)-1:0] digit_count
);
    localparam int BW = 4 * PIN_DIGITS;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int DW = $clog2(PIN_DIGITS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] KEY_CANCEL = 4'hE;
    localparam logic [3:0] KEY_ENTER  = 4'hF;

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, LOCKOUT, NEWPIN} state_t;

    state_t        state;
    logic [BW-1:0] pin_reg;
    logic [BW-1:0] buffer;
    logic          overflow;
    logic [LW-1:0] lock_cnt;
    logic [IW-1:0] idle_cnt;
    logic          change_pend;
    logic          is_digit;
    logic          full;
    logic          match;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign full     = (digit_count == DW'(PIN_DIGITS));
    assign match    = full && !overflow && (buffer == pin_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pin_reg     <= DEFAULT_PIN;
            buffer      <= '0;
            overflow    <= 1'b0;
            lock_cnt    <= '0;
            idle_cnt    <= '0;
            change_pend <= 1'b0;
            pin_correct <= 1'b0;
            pin_wrong   <= 1'b0;
            pin_changed <= 1'b0;
            locked_out  <= 1'b0;
            tries_left  <= TW'(MAX_TRIES);
            digit_count <= '0;
        end else begin
            pin_correct <= 1'b0;
            pin_wrong   <= 1'b0;
            // pin_changed trails the pin_reg commit by one cycle
            pin_changed <= change_pend;
            change_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (is_digit) begin
                        buffer      <= BW'(key_code);
                        digit_count <= DW'(1);
                        overflow    <= 1'b0;
                        idle_cnt    <= '0;
                        state       <= ENTRY;
                    end
                end

                ENTRY, NEWPIN: begin
                    if (is_digit) begin
                        idle_cnt <= '0;
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            buffer      <= (buffer << 4) | BW'(key_code);
                            digit_count <= digit_count + DW'(1);
                        end
                    end else if (key_valid && key_code == KEY_CANCEL) begin
                        buffer      <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                        state       <= IDLE;
                    end else if (key_valid && key_code == KEY_ENTER) begin
                        if (state == ENTRY) begin
                            state <= CHECK;
                        end else begin
                            if (full && !overflow) begin
                                pin_reg     <= buffer;
                                change_pend <= 1'b1;
                            end
                            buffer      <= '0;
                            digit_count <= '0;
                            overflow    <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                        buffer      <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end

                CHECK: begin
                    buffer      <= '0;
                    digit_count <= '0;
                    overflow    <= 1'b0;
                    idle_cnt    <= '0;
                    if (match) begin
                        pin_correct <= 1'b1;
                        tries_left  <= TW'(MAX_TRIES);
                        state       <= prog_en ? NEWPIN : IDLE;
                    end else begin
                        pin_wrong <= 1'b1;
                        if (tries_left <= TW'(1)) begin
                            tries_left <= '0;
                            lock_cnt   <= LW'(LOCKOUT_CYCLES);
                            locked_out <= 1'b1;
                            state      <= LOCKOUT;
                        end else begin
                            tries_left <= tries_left - TW'(1);
                            state      <= IDLE;
                        end
                    end
                end

                LOCKOUT: begin
                    // exit on the count of 1 so locked_out stays high exactly LOCKOUT_CYCLES cycles
                    if (lock_cnt <= LW'(1)) begin
                        lock_cnt   <= '0;
                        locked_out <= 1'b0;
                        tries_left <= TW'(MAX_TRIES);
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: vector table, directed corner sequences,
// and randomized keys checked against a key-level reference model.
module tb_pin_entry_ctrl;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_LEN  = 64;
    localparam int TIMEOUT   = 32;

    logic clk = 1'b0;
    logic rst, key_valid, prog_en;
    logic [3:0] key_code;
    logic pin_correct, pin_wrong, pin_changed, locked_out;
    logic [1:0] tries_left;
    logic [2:0] digit_count;

    int passed = 0;
    int total  = 0;

    pin_entry_ctrl #(
        .PIN_DIGITS(4), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCK_LEN),
        .TIMEOUT_CYCLES(TIMEOUT), .DEFAULT_PIN(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .prog_en(prog_en), .pin_correct(pin_correct), .pin_wrong(pin_wrong),
        .pin_changed(pin_changed), .locked_out(locked_out),
        .tries_left(tries_left), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kv; int kc; bit c; bit w; int tries; int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit kv, int kc, bit c, bit w, int tries, int cnt);
        vec_t v;
        v.kv = kv; v.kc = kc; v.c = c; v.w = w; v.tries = tries; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input bit c, input bit w, input bit ch,
                           input bit lk, input int tr, input int cnt);
        chk({tag, ".pin_correct"}, int'(pin_correct), int'(c));
        chk({tag, ".pin_wrong"},   int'(pin_wrong),   int'(w));
        chk({tag, ".pin_changed"}, int'(pin_changed), int'(ch));
        chk({tag, ".locked_out"},  int'(locked_out),  int'(lk));
        chk({tag, ".tries_left"},  int'(tries_left),  tr);
        chk({tag, ".digit_count"}, int'(digit_count), cnt);
    endtask

    // Drive inputs for one edge; outputs reflecting that edge are sampled 1 time unit later.
    task automatic tick(input bit kv, input int kc);
        key_valid = kv;
        key_code  = 4'(kc);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic key_seq(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte ch = s[i];
            tick(1'b1, (ch >= "0" && ch <= "9") ? int'(ch - "0") : int'(ch - "A") + 10);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        rst = 1'b0;
    endtask

    // ---------------- reference model (key-level) ----------------
    int m_dig[$];
    int m_pin[$];
    bit m_ovf, m_coll, m_prog, m_chk, m_chg;
    int m_idle, m_lock, m_tries;
    bit e_c, e_w, e_ch;

    task automatic model_reset();
        m_dig.delete();
        m_pin = {1, 2, 3, 4};
        m_ovf = 0; m_coll = 0; m_prog = 0; m_chk = 0; m_chg = 0;
        m_idle = 0; m_lock = 0; m_tries = MAX_TRIES;
        e_c = 0; e_w = 0; e_ch = 0;
    endtask

    task automatic model_abandon();
        m_dig.delete();
        m_ovf  = 0;
        m_coll = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit pe);
        bit ok;
        e_c = 0; e_w = 0; e_ch = m_chg; m_chg = 0;
        if (m_chk) begin
            m_chk = 0;
            ok = !m_ovf && (m_dig.size() == 4);
            if (ok) for (int i = 0; i < 4; i++) if (m_dig[i] != m_pin[i]) ok = 0;
            model_abandon();
            if (ok) begin
                e_c = 1; m_tries = MAX_TRIES;
                m_coll = pe; m_prog = pe; m_idle = 0;
            end else begin
                e_w = 1; m_tries--;
                if (m_tries == 0) m_lock = LOCK_LEN;
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = MAX_TRIES;
        end else if (m_coll) begin
            if (kv && kc <= 9) begin
                m_idle = 0;
                if (m_dig.size() < 4) m_dig.push_back(kc); else m_ovf = 1;
            end else if (kv && kc == 14) begin
                model_abandon();
            end else if (kv && kc == 15) begin
                if (m_prog) begin
                    if (m_dig.size() == 4 && !m_ovf) begin m_pin = m_dig; m_chg = 1; end
                    model_abandon();
                end else m_chk = 1;
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) model_abandon();
            end
        end else if (kv && kc <= 9) begin
            m_dig = {kc}; m_ovf = 0; m_coll = 1; m_prog = 0; m_idle = 0;
        end
    endtask

    task automatic wrong_entry(input int exp_tries, input bit exp_lock);
        key_seq("1235F");
        tick(1'b0, 0);
        chk("wrong.pulse", int'(pin_wrong), 1);
        chk("wrong.tries", int'(tries_left), exp_tries);
        chk("wrong.locked", int'(locked_out), int'(exp_lock));
    endtask

    initial begin
        int hi, quiet, kc;
        bit kv;
        int pend[$];

        key_valid = 0; key_code = 0; prog_en = 0; rst = 0;
        reset_dut();
        chk_all("reset", 0, 0, 0, 0, 3, 0);

        // plan 1, plan 3, a wrong entry, key dropped during check, ignored code
        tbl.push_back(V(1,1,0,0,3,1)); tbl.push_back(V(1,2,0,0,3,2));
        tbl.push_back(V(1,3,0,0,3,3)); tbl.push_back(V(1,4,0,0,3,4));
        tbl.push_back(V(1,15,0,0,3,4)); tbl.push_back(V(0,0,1,0,3,0));
        tbl.push_back(V(0,0,0,0,3,0));
        tbl.push_back(V(1,1,0,0,3,1)); tbl.push_back(V(1,2,0,0,3,2));
        tbl.push_back(V(1,14,0,0,3,0)); tbl.push_back(V(1,15,0,0,3,0));
        tbl.push_back(V(1,1,0,0,3,1)); tbl.push_back(V(1,2,0,0,3,2));
        tbl.push_back(V(1,3,0,0,3,3)); tbl.push_back(V(1,4,0,0,3,4));
        tbl.push_back(V(1,15,0,0,3,4)); tbl.push_back(V(0,0,1,0,3,0));
        tbl.push_back(V(1,1,0,0,3,1)); tbl.push_back(V(1,2,0,0,3,2));
        tbl.push_back(V(1,3,0,0,3,3)); tbl.push_back(V(1,5,0,0,3,4));
        tbl.push_back(V(1,15,0,0,3,4)); tbl.push_back(V(0,0,0,1,2,0));
        tbl.push_back(V(0,0,0,0,2,0));
        tbl.push_back(V(1,1,0,0,2,1)); tbl.push_back(V(1,2,0,0,2,2));
        tbl.push_back(V(1,3,0,0,2,3)); tbl.push_back(V(1,4,0,0,2,4));
        tbl.push_back(V(1,15,0,0,2,4)); tbl.push_back(V(1,7,1,0,3,0));
        tbl.push_back(V(1,10,0,0,3,0)); tbl.push_back(V(0,0,0,0,3,0));
        foreach (tbl[i]) begin
            tick(tbl[i].kv, tbl[i].kc);
            chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].w, 0, 0, tbl[i].tries, tbl[i].cnt);
        end

        // plan 2: three wrong entries, lockout length, keys ignored while locked
        reset_dut();
        wrong_entry(2, 0);
        wrong_entry(1, 0);
        wrong_entry(0, 1);
        hi = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) key_seq(i == 4 ? "F" : $sformatf("%0d", i + 1)); else tick(1'b0, 0);
            chk("lock.no_correct", int'(pin_correct), 0);
            chk("lock.no_wrong", int'(pin_wrong), 0);
            if (locked_out) hi++;
        end
        for (int i = 0; i < 200 && locked_out; i++) begin
            tick(1'b0, 0);
            if (locked_out) hi++;
        end
        chk("lock.length", hi, LOCK_LEN);
        chk("lock.released", int'(locked_out), 0);
        chk("lock.tries_restored", int'(tries_left), 3);
        key_seq("1234F"); tick(1'b0, 0);
        chk("lock.after_correct", int'(pin_correct), 1);

        // plan 4: timeout boundary, then overflow entry
        reset_dut();
        key_seq("12");
        for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 0);
        chk("timeout.before", int'(digit_count), 2);
        tick(1'b0, 0);
        chk("timeout.cleared", int'(digit_count), 0);
        chk("timeout.tries", int'(tries_left), 3);
        key_seq("12345F"); tick(1'b0, 0);
        chk("overflow.wrong", int'(pin_wrong), 1);
        chk("overflow.tries", int'(tries_left), 2);

        // plan 5: program a new PIN
        reset_dut();
        prog_en = 1;
        key_seq("1234F"); tick(1'b0, 0);
        chk("prog.correct", int'(pin_correct), 1);
        prog_en = 0;
        key_seq("9876F");
        chk("prog.changed_early", int'(pin_changed), 0);
        tick(1'b0, 0);
        chk("prog.changed", int'(pin_changed), 1);
        tick(1'b0, 0);
        chk("prog.changed_drop", int'(pin_changed), 0);
        key_seq("1234F"); tick(1'b0, 0);
        chk("prog.old_rejected", int'(pin_wrong), 1);
        key_seq("9876F"); tick(1'b0, 0);
        chk("prog.new_accepted", int'(pin_correct), 1);

        // plan 6: reset mid-lockout restores the default PIN
        wrong_entry(2, 0);
        wrong_entry(1, 0);
        wrong_entry(0, 1);
        for (int i = 0; i < 5; i++) tick(1'b0, 0);
        rst = 1'b1; tick(1'b0, 0); rst = 1'b0;
        chk_all("midlock_rst", 0, 0, 0, 0, 3, 0);
        key_seq("1234F"); tick(1'b0, 0);
        chk("midlock_rst.default_pin", int'(pin_correct), 1);

        // randomized phase against the reference model
        reset_dut();
        model_reset();
        quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            kv = 0; kc = 0;
            if (quiet > 0) quiet--;
            else if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                kv = 1; kc = pend.pop_front();
            end else if (pend.size() == 0 && $urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 0) foreach (m_pin[i]) pend.push_back(m_pin[i]);
                else for (int i = 0; i < 4; i++) pend.push_back(int'($urandom_range(1, 4)));
                if ($urandom_range(0, 7) != 0) pend.push_back(15);
            end else if ($urandom_range(0, 199) == 0) quiet = 40;
            else if ($urandom_range(0, 9) < 3) begin
                kv = 1;
                case ($urandom_range(0, 9))
                    0: kc = 14;
                    1: kc = 15;
                    2: kc = int'($urandom_range(10, 13));
                    default: kc = int'($urandom_range(0, 9));
                endcase
            end
            prog_en = ($urandom_range(0, 3) == 0);
            tick(kv, kc);
            model_step(kv, kc, prog_en);
            chk_all($sformatf("rand%0d", n), e_c, e_w, e_ch, m_lock > 0, m_tries, m_dig.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
